// File: rtl/uart_sched_pkg.sv
// ---------------------------------------------------------------------------
// uart_sched_pkg
//   Shared definitions for the UART transmit scheduler:
//     - sched_state_e          : scheduler FSM encoding (IDLE, START, WAIT_DONE)
//     - UART_NOT_BUSY/UART_BUSY: levels of the UART status line (1 = free)
//     - DEFAULT_TIMEOUT_CYCLES : default START abort limit, used only when the
//                                design is built with UART_TX_TIMEOUT_EN
// ---------------------------------------------------------------------------
package uart_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } sched_state_e;

    localparam logic UART_NOT_BUSY = 1'b1;
    localparam logic UART_BUSY     = 1'b0;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd65535;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin selector. Searches req starting at ptr and
//   wrapping modulo NUM_REQ; the first set bit wins. When lock_en is high the
//   search is bypassed and only lock_id may be granted.
//
//   Ports
//     req       in   NUM_REQ  request vector
//     ptr       in   ID_W     first index to search
//     lock_en   in   1        restrict the grant to lock_id
//     lock_id   in   ID_W     locked requester
//     gnt_valid out  1        a requester was selected
//     gnt_id    out  ID_W     selected requester
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               lock_en,
    input  logic [ID_W-1:0]    lock_id,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id
);

    always_comb begin
        int          idx;
        logic [ID_W-1:0] idx_l;

        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        idx_l     = '0;

        if (lock_en) begin
            gnt_valid = req[lock_id];
            gnt_id    = lock_id;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = int'(ptr) + i;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                idx_l = ID_W'(idx);
                if (!gnt_valid && req[idx_l]) begin
                    gnt_valid = 1'b1;
                    gnt_id    = idx_l;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//   Shares one UART transmitter among NUM_REQ byte requesters. A byte is
//   accepted in IDLE when the UART reports free, the winner is picked
//   round-robin, and the scheduler then drives the UART start handshake
//   (uart_transmit low until the UART goes busy, then high until it is free
//   again). A byte with req_last==0 locks the next acceptance to the same
//   requester so multi-byte packets are not interleaved.
//
//   Optional feature: define UART_TX_TIMEOUT_EN to abort a frame that sits in
//   START for TIMEOUT_CYCLES cycles (timeout_err pulses). Without the macro
//   START waits indefinitely and timeout_err is tied low.
//
//   Ports
//     clock          in   1          system clock, rising edge
//     reset          in   1          synchronous, active-low
//     req_valid      in   NUM_REQ    byte pending per requester
//     req_data       in   8*NUM_REQ  byte i on [8i+7:8i]
//     req_last       in   NUM_REQ    byte i ends its packet
//     req_ack        out  NUM_REQ    pulse in the cycle byte i is accepted
//     uart_data      out  8          byte presented to the UART
//     uart_transmit  out  1          start request, 0 = start a frame
//     uart_busy      in   1          UART status, 1 = not busy
//     grant_id       out  ID_W       current owner
//     active         out  1          FSM not in IDLE
//     frame_done     out  1          pulse per completed frame
//     timeout_err    out  1          pulse per aborted frame
// ---------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter  int          NUM_REQ        = 4,
    parameter  int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int          ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [7:0]           uart_data,
    output logic                 uart_transmit,
    input  logic                 uart_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 active,
    output logic                 frame_done,
    output logic                 timeout_err
);

    // A zero limit would abort every frame before the UART could respond.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
        if (id == ID_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return id + ID_W'(1);
    endfunction

    sched_state_e    state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic            last_q, last_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [7:0]      data_q, data_d;
    logic            xmit_q, xmit_d;
    logic            frame_done_q, frame_done_d;

`ifdef UART_TX_TIMEOUT_EN
    logic [31:0]     tmo_cnt_q, tmo_cnt_d;
    logic            tmo_err_q, tmo_err_d;
`endif

    logic            arb_lock_en;
    logic            gnt_valid;
    logic [ID_W-1:0] gnt_id;
    logic            accept;

    // A locked requester that has dropped valid no longer holds the lock, so
    // the others may compete in that same cycle.
    assign arb_lock_en = lock_q && req_valid[grant_q];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .lock_en   (arb_lock_en),
        .lock_id   (grant_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // req_ack is combinational, so it is gated with reset to stay low while
    // reset is held.
    assign accept = reset && (state_q == ST_IDLE) &&
                    (uart_busy == UART_NOT_BUSY) && gnt_valid;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        last_d       = last_q;
        grant_d      = grant_q;
        data_d       = data_q;
        xmit_d       = xmit_q;
        frame_done_d = 1'b0;
        req_ack      = '0;
`ifdef UART_TX_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        tmo_err_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                xmit_d = 1'b1;
                if (lock_q && !req_valid[grant_q]) begin
                    lock_d   = 1'b0;
                    rr_ptr_d = wrap_inc(grant_q);
                end
                if (accept) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (gnt_id == ID_W'(i)) begin
                            data_d = req_data[8*i +: 8];
                            last_d = req_last[i];
                        end
                    end
                    grant_d         = gnt_id;
                    req_ack[gnt_id] = 1'b1;
                    xmit_d          = 1'b0;
                    state_d         = ST_START;
`ifdef UART_TX_TIMEOUT_EN
                    tmo_cnt_d       = '0;
`endif
                end
            end

            ST_START: begin
`ifdef UART_TX_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 32'd1;
`endif
                // The UART going busy means it took the start request.
                if (uart_busy == UART_BUSY) begin
                    xmit_d  = 1'b1;
                    state_d = ST_WAIT_DONE;
                end
`ifdef UART_TX_TIMEOUT_EN
                else if (tmo_cnt_q + 32'd1 == TIMEOUT_CYCLES) begin
                    tmo_err_d = 1'b1;
                    xmit_d    = 1'b1;
                    lock_d    = 1'b0;
                    rr_ptr_d  = wrap_inc(grant_q);
                    state_d   = ST_IDLE;
                end
`endif
            end

            ST_WAIT_DONE: begin
                if (uart_busy == UART_NOT_BUSY) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                    if (last_q) begin
                        lock_d   = 1'b0;
                        rr_ptr_d = wrap_inc(grant_q);
                    end else begin
                        lock_d   = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                xmit_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            last_q       <= 1'b0;
            grant_q      <= '0;
            data_q       <= '0;
            xmit_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            data_q       <= data_d;
            xmit_q       <= xmit_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef UART_TX_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign uart_data     = data_q;
    assign uart_transmit = xmit_q;
    assign grant_id      = grant_q;
    assign active        = (state_q != ST_IDLE);
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//   Directed bench for uart_tx_scheduler. A small UART model raises busy
//   three cycles after uart_transmit falls and stays busy for 40 cycles; a
//   manual busy line replaces it for the stale-busy and stuck-START steps.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic [7:0]     uart_data;
    logic           uart_transmit;
    logic           uart_busy;
    logic [1:0]     grant_id;
    logic           active;
    logic           frame_done;
    logic           timeout_err;

    logic           model_busy;
    logic           man_busy;
    logic           uart_auto;

    int checks   = 0;
    int failures = 0;

    assign uart_busy = uart_auto ? model_busy : man_busy;

    always #5 clock = ~clock;

    uart_tx_scheduler #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ack       (req_ack),
        .uart_data     (uart_data),
        .uart_transmit (uart_transmit),
        .uart_busy     (uart_busy),
        .grant_id      (grant_id),
        .active        (active),
        .frame_done    (frame_done),
        .timeout_err   (timeout_err)
    );

    // UART model
    initial begin
        int lowcnt;
        int busycnt;
        lowcnt     = 0;
        busycnt    = 0;
        model_busy = 1'b1;
        forever begin
            @(negedge clock);
            if (busycnt > 0) begin
                busycnt--;
                if (busycnt == 0) model_busy = 1'b1;
            end else if (uart_auto && uart_transmit == 1'b0) begin
                lowcnt++;
                if (lowcnt == 3) begin
                    model_busy = 1'b0;
                    busycnt    = 40;
                    lowcnt     = 0;
                end
            end else begin
                lowcnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for an acceptance, checks it, and returns one cycle later with the
    // DUT in START so the caller may change the requester inputs.
    task automatic wait_ack(input int exp_id, input logic [7:0] exp_data, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            #1;
            if (req_ack != '0) found = 1'b1;
            else @(negedge clock);
        end
        chk({tag, "_ack_seen"}, 32'(found), 32'd1);
        if (found) begin
            chk({tag, "_ack"}, 32'(req_ack), 32'(1) << exp_id);
            @(negedge clock);
            #1;
            chk({tag, "_ack_pulse"}, 32'(req_ack), 32'd0);
            chk({tag, "_gid"}, 32'(grant_id), 32'(exp_id));
            chk({tag, "_data"}, 32'(uart_data), 32'(exp_data));
            chk({tag, "_start"}, 32'({active, uart_transmit, frame_done}), 32'b100);
        end
    endtask

    // Waits for frame_done and returns in that same cycle.
    task automatic wait_done(input logic [7:0] exp_data, input string tag);
        bit found   = 1'b0;
        bit data_ok = 1'b1;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clock);
            #1;
            if (frame_done === 1'b1) found = 1'b1;
            else if (uart_data !== exp_data) data_ok = 1'b0;
        end
        chk({tag, "_done_seen"}, 32'(found), 32'd1);
        chk({tag, "_data_stable"}, 32'(data_ok), 32'd1);
        chk({tag, "_done_data"}, 32'(uart_data), 32'(exp_data));
        chk({tag, "_done_idle"}, 32'({active, uart_transmit}), 32'b01);
    endtask

    initial begin
        bit flag;
        int hit;
        flag = 1'b0;
        hit  = 0;

        // Reset with a request pending: nothing may be acknowledged.
        reset     = 1'b0;
        req_valid = 4'b0001;
        req_last  = 4'b1111;
        req_data  = {8'hD3, 8'hC2, 8'hB1, 8'h55};
        uart_auto = 1'b1;
        man_busy  = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_transmit", 32'(uart_transmit), 32'd1);
        chk("rst_data", 32'(uart_data), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);

        // Single byte from requester 0.
        @(negedge clock);
        reset = 1'b1;
        wait_ack(0, 8'h55, "single");
        req_valid = 4'b0000;
        wait_done(8'h55, "single");
        @(negedge clock);
        #1;
        chk("single_after", 32'({active, uart_transmit, frame_done, req_ack}), 32'b0100000);

        // rr_ptr is now 1: requester 2 wins, then reset lands in WAIT_DONE.
        req_data[23:16] = 8'h3C;
        req_valid       = 4'b0100;
        wait_ack(2, 8'h3C, "rstmid");
        req_valid = 4'b0000;
        flag = 1'b0;
        for (int i = 0; i < 50 && !flag; i++) begin
            @(negedge clock);
            #1;
            if (uart_transmit === 1'b1) flag = 1'b1;
        end
        chk("rstmid_wait_done", 32'(flag), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        #1;
        chk("rstmid_state", 32'({active, uart_transmit, frame_done}), 32'b010);
        chk("rstmid_data", 32'(uart_data), 32'd0);
        chk("rstmid_gid", 32'(grant_id), 32'd0);
        flag = 1'b0;
        repeat (50) begin
            @(negedge clock);
            #1;
            if (frame_done !== 1'b0) flag = 1'b1;
        end
        chk("rstmid_no_done", 32'(flag), 32'd0);

        // Contention from rr_ptr=0: 0,1,2,3,0.
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'b1111;
        reset     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_ack(k % 4, 8'(8'hA0 + k % 4), $sformatf("contend%0d", k));
            if (k == 4) begin
                req_valid       = 4'b0100;
                req_data[23:16] = 8'hB1;
                req_data[7:0]   = 8'hE0;
                req_last        = 4'b1011;
            end
            wait_done(8'(8'hA0 + k % 4), $sformatf("contend%0d", k));
        end

        // Packet lock: requester 2 keeps the UART while 0 and 1 wait.
        wait_ack(2, 8'hB1, "pkt1");
        req_data[23:16] = 8'hB2;
        req_data[15:8]  = 8'hE1;
        req_valid       = 4'b0111;
        wait_done(8'hB1, "pkt1");
        wait_ack(2, 8'hB2, "pkt2");
        req_data[23:16] = 8'hB3;
        req_last        = 4'b1111;
        wait_done(8'hB2, "pkt2");
        wait_ack(2, 8'hB3, "pkt3");
        req_valid = 4'b0011;
        wait_done(8'hB3, "pkt3");
        wait_ack(0, 8'hE0, "pkt_after");
        req_valid = 4'b0010;
        wait_done(8'hE0, "pkt_after");
        wait_ack(1, 8'hE1, "pkt_next");
        req_valid = 4'b0000;
        wait_done(8'hE1, "pkt_next");

        // Stale busy: UART not free in IDLE, nothing may be accepted.
        uart_auto     = 1'b0;
        man_busy      = 1'b0;
        req_data[7:0] = 8'h77;
        req_valid     = 4'b0001;
        flag = 1'b0;
        repeat (5) begin
            @(negedge clock);
            #1;
            if (req_ack != '0 || active) flag = 1'b1;
        end
        chk("stale_hold", 32'(flag), 32'd0);
        @(negedge clock);
        man_busy = 1'b1;
        wait_ack(0, 8'h77, "stale");
        req_valid = 4'b0000;
        uart_auto = 1'b1;
        wait_done(8'h77, "stale");

        // UART never goes busy: START is stuck.
        uart_auto      = 1'b0;
        man_busy       = 1'b1;
        req_data[15:8] = 8'h99;
        req_valid      = 4'b0010;
        wait_ack(1, 8'h99, "stuck");
        req_valid = 4'b0000;
`ifdef UART_TX_TIMEOUT_EN
        hit = 0;
        for (int i = 2; i <= 40 && hit == 0; i++) begin
            @(negedge clock);
            #1;
            if (timeout_err === 1'b1) hit = i;
        end
        chk("tmo_cycle", 32'(hit), 32'd17);
        chk("tmo_state", 32'({active, uart_transmit, frame_done}), 32'b010);
        @(negedge clock);
        #1;
        chk("tmo_pulse", 32'(timeout_err), 32'd0);
`else
        flag = 1'b0;
        repeat (30) begin
            @(negedge clock);
            #1;
            if (timeout_err !== 1'b0 || active !== 1'b1 || uart_transmit !== 1'b0) flag = 1'b1;
        end
        chk("notmo_wait", 32'(flag), 32'd0);
        @(negedge clock);
        man_busy = 1'b0;
        @(negedge clock);
        man_busy = 1'b1;
        wait_done(8'h99, "notmo");
        chk("notmo_err", 32'(timeout_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
